// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded instruction and operands, applies the
// write-back bypass, inserts bubbles on load-use/flush and counts them.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [4:0]        id_rd,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_mem_read,
    input  logic              id_reg_write,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    input  logic              ex_hold,
    output logic              id_ready,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_imm,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_mem_read,
    output logic              ex_reg_write,
    output logic [CNT_W-1:0]  bubble_count
);

    logic              load_use_s;
    logic              wb_live_s;
    logic              hold_fix1_s;
    logic              hold_fix2_s;
    logic [XLEN-1:0]   byp1_s;
    logic [XLEN-1:0]   byp2_s;
    logic [CNT_W-1:0]  cnt_next_s;

    // Hazard detection, write-back bypass selection and saturating counter increment
    always_comb begin
        load_use_s  = ex_valid && ex_mem_read && (ex_rd != 5'd0) && id_valid &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));
        wb_live_s   = wb_reg_write && (wb_rd != 5'd0);
        hold_fix1_s = ex_valid && wb_live_s && (wb_rd == ex_rs1);
        hold_fix2_s = ex_valid && wb_live_s && (wb_rd == ex_rs2);
        if (wb_live_s && (wb_rd == id_rs1)) begin
            byp1_s = wb_data;
        end else begin
            byp1_s = id_rs1_data;
        end
        if (wb_live_s && (wb_rd == id_rs2)) begin
            byp2_s = wb_data;
        end else begin
            byp2_s = id_rs2_data;
        end
        if (bubble_count == {CNT_W{1'b1}}) begin
            cnt_next_s = bubble_count;
        end else begin
            cnt_next_s = bubble_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign id_ready = !ex_hold && !load_use_s;

    // Stage register: flush > hold (with operand refresh) > load-use bubble > capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid     <= 1'b0;
            ex_pc        <= {XLEN{1'b0}};
            ex_imm       <= {XLEN{1'b0}};
            ex_rs1_data  <= {XLEN{1'b0}};
            ex_rs2_data  <= {XLEN{1'b0}};
            ex_rs1       <= 5'd0;
            ex_rs2       <= 5'd0;
            ex_rd        <= 5'd0;
            ex_ctrl      <= {CTRL_W{1'b0}};
            ex_mem_read  <= 1'b0;
            ex_reg_write <= 1'b0;
            bubble_count <= {CNT_W{1'b0}};
        end else if (flush || (!ex_hold && load_use_s)) begin
            ex_valid     <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_reg_write <= 1'b0;
            bubble_count <= cnt_next_s;
        end else if (ex_hold) begin
            if (hold_fix1_s) begin
                ex_rs1_data <= wb_data;
            end
            if (hold_fix2_s) begin
                ex_rs2_data <= wb_data;
            end
        end else begin
            ex_valid     <= id_valid;
            ex_pc        <= id_pc;
            ex_imm       <= id_imm;
            ex_rs1_data  <= byp1_s;
            ex_rs2_data  <= byp2_s;
            ex_rs1       <= id_rs1;
            ex_rs2       <= id_rs2;
            ex_rd        <= id_rd;
            ex_ctrl      <= id_ctrl;
            ex_mem_read  <= id_mem_read;
            ex_reg_write <= id_reg_write;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: driver updates a reference model and queues the
// expected EX state; a monitor pops and compares one entry after every clock edge.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_uses_rs1, id_uses_rs2, id_mem_read, id_reg_write;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm, wb_data;
    logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
    logic [7:0]  id_ctrl;
    logic        wb_reg_write, flush, ex_hold;
    logic        id_ready, ex_valid, ex_mem_read, ex_reg_write;
    logic [31:0] ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [7:0]  ex_ctrl;
    logic [15:0] bubble_count;

    id_ex_stage #(.XLEN(32), .CTRL_W(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_ctrl(id_ctrl), .id_mem_read(id_mem_read), .id_reg_write(id_reg_write),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .ex_hold(ex_hold), .id_ready(id_ready), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
        .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, imm, rs1d, rs2d;
        logic [4:0]  rs1, rs2, rd;
        logic [7:0]  ctrl;
        logic        mr, rw;
    } ex_t;

    typedef struct packed {
        ex_t         st;
        logic [15:0] cnt;
    } exp_t;

    exp_t        q[$];
    ex_t         m;
    int unsigned mcnt;
    int          n_pass = 0;
    int          n_total = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        n_total++;
        if (act !== req) $display("FAIL %s actual=%0h required=%0h", name, act, req);
        else n_pass++;
    endtask

    function automatic logic [15:0] sat_cnt();
        return (mcnt > 32'd65535) ? 16'hFFFF : mcnt[15:0];
    endfunction

    // Monitor: after every edge compare the DUT against the oldest queued expectation
    always @(posedge clk) begin
        exp_t e;
        ex_t  a;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = '{ex_valid, ex_pc, ex_imm, ex_rs1_data, ex_rs2_data, ex_rs1, ex_rs2, ex_rd,
                  ex_ctrl, ex_mem_read, ex_reg_write};
            chk("ex_state", a, e.st);
            chk("bubble_count", bubble_count, e.cnt);
        end
    end

    task automatic idle();
        id_valid = 1'b0; id_pc = 32'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_rd = 5'd0;
        id_rs1_data = 32'd0; id_rs2_data = 32'd0; id_imm = 32'd0; id_ctrl = 8'd0;
        id_mem_read = 1'b0; id_reg_write = 1'b0;
        wb_reg_write = 1'b0; wb_rd = 5'd0; wb_data = 32'd0; flush = 1'b0; ex_hold = 1'b0;
    endtask

    // Called at a negedge with inputs already set: checks id_ready, advances the model, waits
    task automatic cycle();
        logic lu;
        ex_t  n;
        #1;
        lu = m.valid && m.mr && (m.rd != 5'd0) && id_valid &&
             ((id_uses_rs1 && id_rs1 == m.rd) || (id_uses_rs2 && id_rs2 == m.rd));
        chk("id_ready", id_ready, !ex_hold && !lu);
        n = m;
        if (flush || (!ex_hold && lu)) begin
            n.valid = 1'b0; n.mr = 1'b0; n.rw = 1'b0; mcnt++;
        end else if (ex_hold) begin
            if (m.valid && wb_reg_write && wb_rd != 5'd0 && wb_rd == m.rs1) n.rs1d = wb_data;
            if (m.valid && wb_reg_write && wb_rd != 5'd0 && wb_rd == m.rs2) n.rs2d = wb_data;
        end else begin
            n.valid = id_valid; n.pc = id_pc; n.imm = id_imm;
            n.rs1d = (wb_reg_write && wb_rd != 5'd0 && wb_rd == id_rs1) ? wb_data : id_rs1_data;
            n.rs2d = (wb_reg_write && wb_rd != 5'd0 && wb_rd == id_rs2) ? wb_data : id_rs2_data;
            n.rs1 = id_rs1; n.rs2 = id_rs2; n.rd = id_rd; n.ctrl = id_ctrl;
            n.mr = id_mem_read; n.rw = id_reg_write;
        end
        m = n;
        q.push_back('{n, sat_cnt()});
        @(negedge clk);
    endtask

    initial begin
        idle();
        reset = 1'b1;
        m = '0;
        mcnt = 0;
        @(negedge clk);
        chk("reset_valid", ex_valid, 1'b0);
        chk("reset_count", bubble_count, 16'd0);
        reset = 1'b0;

        // pass-through
        id_valid = 1'b1; id_pc = 32'h10; id_rs1 = 5'd1; id_rs2 = 5'd2; id_uses_rs1 = 1'b1;
        id_uses_rs2 = 1'b1; id_rd = 5'd6; id_rs1_data = 32'hC; id_rs2_data = 32'hD; id_imm = 32'd4;
        cycle();
        chk("t2_pc", ex_pc, 32'h10);
        chk("t2_rs1", ex_rs1_data, 32'hC);
        chk("t2_rs2", ex_rs2_data, 32'hD);

        // write-back bypass, then x0 never bypassed
        id_rs1 = 5'd5; id_rs1_data = 32'd0; wb_reg_write = 1'b1; wb_rd = 5'd5; wb_data = 32'hAB;
        cycle();
        chk("t3_bypass", ex_rs1_data, 32'hAB);
        id_rs1 = 5'd0; wb_rd = 5'd0;
        cycle();
        chk("t3_x0", ex_rs1_data, 32'd0);

        // load-use: lw x3 then add x4,x3,x1
        idle();
        id_valid = 1'b1; id_rd = 5'd3; id_rs1 = 5'd2; id_uses_rs1 = 1'b1;
        id_mem_read = 1'b1; id_reg_write = 1'b1;
        cycle();
        id_rs1 = 5'd3; id_rs2 = 5'd1; id_uses_rs2 = 1'b1; id_rd = 5'd4; id_mem_read = 1'b0;
        #1 chk("t4_ready", id_ready, 1'b0);
        cycle();
        chk("t4_bubble", ex_valid, 1'b0);
        chk("t4_count", bubble_count, 16'd1);
        cycle();
        chk("t4_add_valid", ex_valid, 1'b1);
        chk("t4_add_rd", ex_rd, 5'd4);

        // hold with write-back to a held operand
        idle();
        id_valid = 1'b1; id_pc = 32'h40; id_rs2 = 5'd7; id_uses_rs2 = 1'b1; id_rd = 5'd8;
        id_rs2_data = 32'h11; id_reg_write = 1'b1;
        cycle();
        id_pc = 32'h44; id_rd = 5'd9; ex_hold = 1'b1;
        wb_reg_write = 1'b1; wb_rd = 5'd7; wb_data = 32'h55;
        cycle();
        chk("t5_rs2", ex_rs2_data, 32'h55);
        chk("t5_pc", ex_pc, 32'h40);
        chk("t5_rd", ex_rd, 5'd8);

        // flush beats hold while a load-use is also present
        idle();
        id_valid = 1'b1; id_rd = 5'd9; id_mem_read = 1'b1; id_reg_write = 1'b1;
        cycle();
        id_rs1 = 5'd9; id_uses_rs1 = 1'b1; id_rd = 5'd10; id_mem_read = 1'b0;
        flush = 1'b1; ex_hold = 1'b1;
        cycle();
        chk("t6_valid", ex_valid, 1'b0);
        chk("t6_count", bubble_count, 16'd2);

        // randomized traffic with small register indices to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            id_valid = ($urandom_range(0, 3) != 0);
            id_pc = $urandom; id_imm = $urandom; id_ctrl = 8'($urandom);
            id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
            id_rd = 5'($urandom_range(0, 7));
            id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom);
            id_rs1_data = $urandom; id_rs2_data = $urandom;
            id_mem_read = ($urandom_range(0, 2) == 0); id_reg_write = 1'($urandom);
            wb_reg_write = 1'($urandom); wb_rd = 5'($urandom_range(0, 7)); wb_data = $urandom;
            flush = ($urandom_range(0, 9) == 0); ex_hold = ($urandom_range(0, 4) == 0);
            cycle();
        end

        // drive the bubble counter into saturation
        idle();
        flush = 1'b1;
        for (int i = 0; i < 65540; i++) cycle();
        chk("t6_saturate", bubble_count, 16'hFFFF);

        // asynchronous reset in the middle of a live instruction
        idle();
        id_valid = 1'b1; id_rd = 5'd12; id_reg_write = 1'b1;
        cycle();
        reset = 1'b1;
        #1;
        chk("t1_valid", ex_valid, 1'b0);
        chk("t1_regwrite", ex_reg_write, 1'b0);
        chk("t1_count", bubble_count, 16'd0);
        m = '0;
        mcnt = 0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) cycle();

        @(posedge clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
